rvcore_mem_arbiter: RTL and testbench

//  Shares one memory-controller request port between NCORES RV32 pipelined cores (SMP harts).

---
 rtl/rvcore_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_rvcore_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvcore_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rvcore_mem_arbiter
// Purpose : Round-robin arbiter sharing one memory-controller request port
//           between NCORES harts; one transaction in flight at a time, with
//           a watchdog that forces an error completion if the controller
//           stays busy too long.
// Revision: 1.0  initial release
// ============================================================================
module rvcore_mem_arbiter #(
  parameter int NCORES  = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic [NCORES-1:0]     s_req,
  input  logic [32*NCORES-1:0]  s_addr,
  input  logic [32*NCORES-1:0]  s_wdata,
  input  logic [3*NCORES-1:0]   s_ctrl,
  output logic [NCORES-1:0]     s_gnt,
  output logic [NCORES-1:0]     s_done,
  output logic                  s_err,
  output logic [127:0]          s_rdata,
  output logic                  m_req,
  output logic [31:0]           m_addr,
  output logic [31:0]           m_wdata,
  output logic [2:0]            m_ctrl,
  input  logic                  m_busy,
  input  logic [127:0]          m_rdata,
  output logic                  arb_idle
);

  localparam int              IDXW     = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [15:0]     TMO      = 16'(TIMEOUT);
  localparam logic [IDXW-1:0] RR_RESET = IDXW'(NCORES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [IDXW-1:0]   r_rr_ptr;
  logic [IDXW-1:0]   r_owner;
  logic              r_wait_first;
  logic [15:0]       r_wd_cnt;

  logic              w_win_found;
  logic [IDXW-1:0]   w_winner;
  logic [NCORES-1:0] w_win_onehot;
  logic [31:0]       w_win_addr;
  logic [31:0]       w_win_wdata;
  logic [2:0]        w_win_ctrl;
  logic [15:0]       w_cnt_inc;
  logic              w_grant;
  logic              w_complete_ok;
  logic              w_complete_tmo;

  // Round-robin pick: scan starting just after the last owner, then mux the winner's payload.
  always_comb begin
    int idx;
    idx          = 0;
    w_win_found  = 1'b0;
    w_winner     = '0;
    w_win_onehot = '0;
    w_win_addr   = '0;
    w_win_wdata  = '0;
    w_win_ctrl   = '0;
    for (int k = 1; k <= NCORES; k++) begin
      idx = (int'(r_rr_ptr) + k) % NCORES;
      if (!w_win_found && s_req[idx]) begin
        w_win_found = 1'b1;
        w_winner    = IDXW'(idx);
      end
    end
    for (int i = 0; i < NCORES; i++) begin
      if (w_winner == IDXW'(i)) begin
        w_win_onehot[i] = 1'b1;
        w_win_addr      = s_addr[32*i +: 32];
        w_win_wdata     = s_wdata[32*i +: 32];
        w_win_ctrl      = s_ctrl[3*i +: 3];
      end
    end
  end

  // Watchdog increment saturates so a huge TIMEOUT can never wrap past the limit.
  assign w_cnt_inc = (r_wd_cnt == 16'hFFFF) ? r_wd_cnt : (r_wd_cnt + 16'd1);

  // Next-state logic plus the one-cycle event strobes consumed by the datapath.
  always_comb begin
    state_next     = state;
    w_grant        = 1'b0;
    w_complete_ok  = 1'b0;
    w_complete_tmo = 1'b0;
    case (state)
      IDLE: begin
        if (|s_req) begin
          w_grant    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // The controller only raises busy the cycle after the strobe, so the
        // first WAIT cycle's busy value is meaningless.
        if (!r_wait_first) begin
          if (!m_busy) begin
            w_complete_ok = 1'b1;
            state_next    = DONE;
          end else if (w_cnt_inc >= TMO) begin
            w_complete_tmo = 1'b1;
            state_next     = DONE;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_X) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: grant latch, request strobe, watchdog, completion pulses and read data.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_rr_ptr     <= RR_RESET;
      r_owner      <= '0;
      r_wait_first <= 1'b0;
      r_wd_cnt     <= '0;
      s_gnt        <= '0;
      s_done       <= '0;
      s_err        <= 1'b0;
      s_rdata      <= '0;
      m_req        <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_ctrl       <= '0;
    end else begin
      m_req  <= 1'b0;
      s_done <= '0;
      s_err  <= 1'b0;
      if (w_grant) begin
        r_owner <= w_winner;
        s_gnt   <= w_win_onehot;
        m_addr  <= w_win_addr;
        m_wdata <= w_win_wdata;
        m_ctrl  <= w_win_ctrl;
        m_req   <= 1'b1;
      end
      if (state == ISSUE) begin
        r_wd_cnt     <= '0;
        r_wait_first <= 1'b1;
      end
      if (state == WAIT) begin
        r_wait_first <= 1'b0;
        if (!r_wait_first && m_busy) r_wd_cnt <= w_cnt_inc;
      end
      // Completion pulses are registered so they appear during the DONE cycle.
      if (w_complete_ok) begin
        s_rdata <= m_rdata;
        s_done  <= s_gnt;
      end
      if (w_complete_tmo) begin
        s_done <= s_gnt;
        s_err  <= 1'b1;
      end
      if (state == DONE) begin
        s_gnt    <= '0;
        r_rr_ptr <= r_owner;
      end
    end
  end

  assign arb_idle = (state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rvcore_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rvcore_mem_arbiter
// Purpose : Self-checking bench for rvcore_mem_arbiter (NCORES=2, TIMEOUT=8)
//           with a small memory-controller busy model.
// Revision: 1.0  initial release
// ============================================================================
module tb_rvcore_mem_arbiter;

  logic         CLK = 1'b0;
  logic         RST_X;
  logic [1:0]   s_req;
  logic [63:0]  s_addr;
  logic [63:0]  s_wdata;
  logic [5:0]   s_ctrl;
  logic [1:0]   s_gnt;
  logic [1:0]   s_done;
  logic         s_err;
  logic [127:0] s_rdata;
  logic         m_req;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [2:0]   m_ctrl;
  logic         m_busy;
  logic [127:0] m_rdata;
  logic         arb_idle;

  int total = 0;
  int bad   = 0;

  int busy_len  = 1;
  bit hold_busy = 1'b0;
  int bcnt      = 0;
  logic [127:0] last_rd;

  rvcore_mem_arbiter #(.NCORES(2), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_ctrl(s_ctrl),
    .s_gnt(s_gnt), .s_done(s_done), .s_err(s_err), .s_rdata(s_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_ctrl(m_ctrl),
    .m_busy(m_busy), .m_rdata(m_rdata), .arb_idle(arb_idle)
  );

  always #5 CLK = ~CLK;

  // Controller model: busy rises the cycle after m_req and lasts busy_len cycles.
  always @(posedge CLK) begin
    if (!RST_X) begin
      m_busy <= 1'b0;
      bcnt   <= 0;
    end else if (m_req) begin
      m_busy <= 1'b1;
      bcnt   <= busy_len - 1;
    end else if (m_busy && !hold_busy) begin
      if (bcnt == 0) m_busy <= 1'b0;
      else           bcnt   <= bcnt - 1;
    end
  end

  typedef struct {
    logic [1:0]   req;
    logic [31:0]  a0, a1, w0, w1;
    logic [2:0]   c0, c1;
    int           blen;
    logic [127:0] rd;
    logic [1:0]   exp_gnt;
    logic [31:0]  exp_addr, exp_wdata;
    logic [2:0]   exp_ctrl;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Waits for a done pulse; lat counts negedges from the call.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      lat++;
      if (s_done != 2'b00) return;
    end
    check("done_wait_expired", 128'd0, 128'd1);
  endtask

  // Runs one transaction from an IDLE cycle and checks grant, payload, latency and result.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    s_req    = v.req;
    s_addr   = {v.a1, v.a0};
    s_wdata  = {v.w1, v.w0};
    s_ctrl   = {v.c1, v.c0};
    busy_len = v.blen;
    m_rdata  = v.rd;
    @(negedge CLK);
    check({tag, "_mreq"},  {127'd0, m_req}, 128'd1);
    check({tag, "_gnt"},   {126'd0, s_gnt}, {126'd0, v.exp_gnt});
    check({tag, "_addr"},  {96'd0, m_addr}, {96'd0, v.exp_addr});
    check({tag, "_wdata"}, {96'd0, m_wdata}, {96'd0, v.exp_wdata});
    check({tag, "_ctrl"},  {125'd0, m_ctrl}, {125'd0, v.exp_ctrl});
    wait_done(lat);
    check({tag, "_lat"},   128'(lat), 128'(2 + v.blen));
    check({tag, "_done"},  {126'd0, s_done}, {126'd0, v.exp_gnt});
    check({tag, "_err"},   {127'd0, s_err}, 128'd0);
    check({tag, "_rdata"}, s_rdata, v.rd);
    last_rd = v.rd;
    s_req = 2'b00;
    @(negedge CLK);
    check({tag, "_idle"},  {126'd0, s_done, arb_idle}, 128'd1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{2'b01, 32'h8000_0010, 32'h0, 32'h1111_0000, 32'h0, 3'd2, 3'd0, 3,
                {4{32'hA5A5_A5A5}}, 2'b01, 32'h8000_0010, 32'h1111_0000, 3'd2};
    vecs[1] = '{2'b10, 32'h0, 32'h1234_5678, 32'h0, 32'hCAFE_0001, 3'd0, 3'd5, 1,
                {4{32'h0BAD_F00D}}, 2'b10, 32'h1234_5678, 32'hCAFE_0001, 3'd5};
    vecs[2] = '{2'b11, 32'h0000_0100, 32'h0000_0200, 32'hAAAA_0001, 32'hBBBB_0002, 3'd1, 3'd6, 2,
                {4{32'h0101_0101}}, 2'b01, 32'h0000_0100, 32'hAAAA_0001, 3'd1};
    vecs[3] = '{2'b11, 32'h0000_0100, 32'h0000_0200, 32'hAAAA_0001, 32'hBBBB_0002, 3'd1, 3'd6, 1,
                {4{32'h0202_0202}}, 2'b10, 32'h0000_0200, 32'hBBBB_0002, 3'd6};
    vecs[4] = '{2'b01, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 32'h0, 3'd7, 3'd0, 2,
                {32'h1, 32'h2, 32'h3, 32'h4}, 2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 3'd7};

    RST_X = 1'b0; s_req = '0; s_addr = '0; s_wdata = '0; s_ctrl = '0; m_rdata = '0;
    last_rd = '0;
    repeat (3) @(negedge CLK);
    check("rst_gnt",   {126'd0, s_gnt}, 128'd0);
    check("rst_done",  {126'd0, s_done}, 128'd0);
    check("rst_mreq",  {127'd0, m_req}, 128'd0);
    check("rst_addr",  {96'd0, m_addr}, 128'd0);
    check("rst_rdata", s_rdata, 128'd0);
    check("rst_idle",  {127'd0, arb_idle}, 128'd1);
    RST_X = 1'b1;

    // Both cores held from reset: core 0, core 1, core 0.
    s_addr = {32'hB000_0000, 32'hA000_0000}; busy_len = 1; m_rdata = 128'h77;
    s_req = 2'b11;
    wait_done(lat);
    check("rr1_lat",  128'(lat), 128'd4);
    check("rr1_done", {126'd0, s_done}, 128'b01);
    check("rr1_addr", {96'd0, m_addr}, {96'd0, 32'hA000_0000});
    wait_done(lat);
    check("rr2_lat",  128'(lat), 128'd5);
    check("rr2_done", {126'd0, s_done}, 128'b10);
    check("rr2_addr", {96'd0, m_addr}, {96'd0, 32'hB000_0000});
    wait_done(lat);
    check("rr3_done", {126'd0, s_done}, 128'b01);
    s_req = 2'b00;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Core 1 arrives while core 0 is waiting; m_addr changes only at core 1's grant.
    s_addr = {32'h0000_2000, 32'h0000_1000}; busy_len = 4; m_rdata = 128'hDEAD;
    s_req = 2'b01;
    @(negedge CLK);
    @(negedge CLK);
    s_req = 2'b11;
    wait_done(lat);
    check("late_done0", {126'd0, s_done}, 128'b01);
    s_req = 2'b10;
    @(negedge CLK);
    check("late_idle_addr", {96'd0, m_addr}, {96'd0, 32'h0000_1000});
    @(negedge CLK);
    check("late_gnt1",  {126'd0, s_gnt}, 128'b10);
    check("late_addr1", {96'd0, m_addr}, {96'd0, 32'h0000_2000});
    wait_done(lat);
    check("late_done1", {126'd0, s_done}, 128'b10);
    last_rd = 128'hDEAD;
    s_req = 2'b00;
    @(negedge CLK);

    // Watchdog: busy stuck high, expect error completion with read data untouched.
    hold_busy = 1'b1; busy_len = 1; m_rdata = 128'h5555;
    s_req = 2'b01;
    @(negedge CLK);
    wait_done(lat);
    check("tmo_lat",   128'(lat), 128'd10);
    check("tmo_done",  {126'd0, s_done}, 128'b01);
    check("tmo_err",   {127'd0, s_err}, 128'd1);
    check("tmo_rdata", s_rdata, last_rd);
    s_req = 2'b00; hold_busy = 1'b0;
    @(negedge CLK);
    check("tmo_err_clr", {125'd0, s_err, s_done}, 128'd0);
    repeat (2) @(negedge CLK);

    // Reset in the middle of WAIT abandons the transaction.
    hold_busy = 1'b1; s_addr = {32'h0000_3000, 32'h0000_4000};
    s_req = 2'b01;
    repeat (3) @(negedge CLK);
    RST_X = 1'b0;
    @(negedge CLK);
    check("mrst_gnt",   {126'd0, s_gnt}, 128'd0);
    check("mrst_done",  {126'd0, s_done}, 128'd0);
    check("mrst_addr",  {96'd0, m_addr}, 128'd0);
    check("mrst_rdata", s_rdata, 128'd0);
    check("mrst_idle",  {127'd0, arb_idle}, 128'd1);
    RST_X = 1'b1; hold_busy = 1'b0;
    run_vec('{2'b10, 32'h0000_4000, 32'h0000_3000, 32'h0, 32'h9, 3'd0, 3'd3, 1,
              128'h33, 2'b10, 32'h0000_3000, 32'h9, 3'd3}, "post_rst");

    // Core 0 withdraws during WAIT: completion still pulses, no re-grant.
    busy_len = 2; m_rdata = 128'h66;
    s_req = 2'b01;
    repeat (2) @(negedge CLK);
    s_req = 2'b00;
    wait_done(lat);
    check("drop_done", {126'd0, s_done}, 128'b01);
    repeat (2) @(negedge CLK);
    check("drop_nogrant", {125'd0, m_req, s_gnt}, 128'd0);
    check("drop_idle", {127'd0, arb_idle}, 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
